// File: rtl/vga_draw_pkg.sv
// Shared drawing definitions: controller state encoding, default geometry and widths,
// and the octant sign/swap tables used to expand one midpoint step into eight points.
package vga_draw_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        INIT  = 3'd2,
        PLOT  = 3'd3,
        STEP  = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam int DEF_X_W   = 8;
    localparam int DEF_Y_W   = 7;
    localparam int DEF_R_W   = 6;
    localparam int DEF_COL_W = 3;
    localparam int DEF_H_RES = 160;
    localparam int DEF_V_RES = 120;

    // Bit k describes octant k: swap puts py on x / px on y, neg flips that axis offset.
    localparam logic [7:0] OCT_NEG_X = 8'b1010_1010;
    localparam logic [7:0] OCT_NEG_Y = 8'b1100_1100;
    localparam logic [7:0] OCT_SWAP  = 8'b1111_0000;

endpackage

// File: rtl/circle_plotter_if.sv
// Pixel write port between the circle plotter and the VGA adapter.
interface circle_plotter_if #(
    parameter int X_W   = 8,
    parameter int Y_W   = 7,
    parameter int COL_W = 3
);
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [COL_W-1:0] col;
    logic             plot;
    logic             plot_rdy;

    // Valid/ready: a pixel transfers on a rising edge where plot && plot_rdy are both high;
    // once plot is raised the master holds x, y and col stable until that transfer.
    modport master (output x, y, col, plot, input plot_rdy);
    modport slave  (input x, y, col, plot, output plot_rdy);
endinterface

// File: rtl/circle_plotter_pixel_clip.sv
// One axis of pixel placement: signed centre+offset, visibility test against the
// resolution, and the coordinate truncated back to the port width.
module pixel_clip #(
    parameter int C_W = 8,
    parameter int S_W = 10,
    parameter int RES = 160
) (
    input  logic [C_W-1:0]        centre,
    input  logic signed [S_W-1:0] offset,
    output logic                  in_range,
    output logic [C_W-1:0]        coord
);
    localparam logic signed [S_W-1:0] RES_S = S_W'(RES);

    logic signed [S_W-1:0] sum;

    always_comb begin
        sum      = $signed({{(S_W-C_W){1'b0}}, centre}) + offset;
        in_range = !sum[S_W-1] && (sum < RES_S);
        coord    = sum[C_W-1:0];
    end
endmodule

// File: rtl/circle_plotter.sv
// Midpoint circle outline plotter with full-screen clear, clipping and plot back-pressure.
// Define CIRCLE_FILL_EN to draw filled discs as four horizontal spans per step.
module circle_plotter
    import vga_draw_pkg::*;
#(
    parameter int X_W        = DEF_X_W,
    parameter int Y_W        = DEF_Y_W,
    parameter int R_W        = DEF_R_W,
    parameter int COL_W      = DEF_COL_W,
    parameter int H_RES      = DEF_H_RES,
    parameter int V_RES      = DEF_V_RES,
    parameter int CLR_COLOUR = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear,
    input  logic [X_W-1:0]   cx,
    input  logic [Y_W-1:0]   cy,
    input  logic [R_W-1:0]   radius,
    input  logic [COL_W-1:0] colour,
    circle_plotter_if.master pix,
    output logic             busy,
    output logic             done,
    output state_t           state_dbg
);
    localparam int S_W = ((X_W > Y_W) ? X_W : Y_W) + 2;
    localparam int Q_W = R_W + 2;
    localparam int D_W = R_W + 3;
    localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

    state_t                state, state_nx;
    logic [X_W-1:0]        cx_q, x_cnt, x_pt;
    logic [Y_W-1:0]        cy_q, y_cnt, y_pt;
    logic [R_W-1:0]        r_q;
    logic [COL_W-1:0]      col_q;
    logic signed [Q_W-1:0] px, py, px_nx, py_nx;
    logic signed [D_W-1:0] d, d_nx, px_d, py_d, r_d;
    logic [2:0]            k;
    logic signed [S_W-1:0] px_s, py_s, off_x, off_y;
    logic                  x_in, y_in, adv, last_pt;
`ifdef CIRCLE_FILL_EN
    logic signed [S_W-1:0] sx, half, row;
    logic                  span_end;
`endif

    assign state_dbg = state;

    always_comb begin
        px_s = {{(S_W-Q_W){px[Q_W-1]}}, px};
        py_s = {{(S_W-Q_W){py[Q_W-1]}}, py};
`ifdef CIRCLE_FILL_EN
        // k[1] picks the py-rows (span half-width px) or px-rows (half-width py); k[0] the side.
        half     = k[1] ? py_s : px_s;
        row      = k[1] ? px_s : py_s;
        off_x    = sx - half;
        off_y    = k[0] ? -row : row;
        span_end = (sx == half + half);
        last_pt  = span_end && (k[1:0] == 2'b11);
`else
        off_x   = OCT_SWAP[k] ? py_s : px_s;
        off_y   = OCT_SWAP[k] ? px_s : py_s;
        if (OCT_NEG_X[k]) off_x = -off_x;
        if (OCT_NEG_Y[k]) off_y = -off_y;
        last_pt = (k == 3'd7);
`endif
        px_d = {{(D_W-Q_W){px[Q_W-1]}}, px};
        py_d = {{(D_W-Q_W){py[Q_W-1]}}, py};
        r_d  = {{(D_W-R_W){1'b0}}, r_q};
        if (d[D_W-1]) begin
            d_nx  = d + (px_d <<< 2) + D_W'(6);
            py_nx = py;
        end else begin
            d_nx  = d + ((px_d - py_d) <<< 2) + D_W'(10);
            py_nx = py - Q_W'(1);
        end
        px_nx = px + Q_W'(1);
    end

    pixel_clip #(.C_W(X_W), .S_W(S_W), .RES(H_RES)) u_clip_x (
        .centre(cx_q), .offset(off_x), .in_range(x_in), .coord(x_pt)
    );
    pixel_clip #(.C_W(Y_W), .S_W(S_W), .RES(V_RES)) u_clip_y (
        .centre(cy_q), .offset(off_y), .in_range(y_in), .coord(y_pt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        pix.plot = 1'b0;
        pix.x    = '0;
        pix.y    = '0;
        pix.col  = '0;
        done     = 1'b0;
        busy     = (state != IDLE);
        adv      = 1'b0;
        case (state)
            IDLE: begin
                if (clear)      state_nx = CLEAR;
                else if (start) state_nx = INIT;
            end
            CLEAR: begin
                pix.plot = 1'b1;
                pix.x    = x_cnt;
                pix.y    = y_cnt;
                pix.col  = COL_W'(CLR_COLOUR);
                if (pix.plot_rdy && x_cnt == X_LAST && y_cnt == Y_LAST) state_nx = DONE;
            end
            INIT: state_nx = PLOT;
            PLOT: begin
                // Clipped points never raise plot, so they advance without waiting on the sink.
                pix.plot = x_in && y_in;
                if (x_in && y_in) begin
                    pix.x   = x_pt;
                    pix.y   = y_pt;
                    pix.col = col_q;
                end
                adv = !(x_in && y_in) || pix.plot_rdy;
                if (adv && last_pt) state_nx = STEP;
            end
            STEP: state_nx = (px_nx <= py_nx) ? PLOT : DONE;
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cx_q  <= '0;
            cy_q  <= '0;
            r_q   <= '0;
            col_q <= '0;
            x_cnt <= '0;
            y_cnt <= '0;
            px    <= '0;
            py    <= '0;
            d     <= '0;
            k     <= '0;
`ifdef CIRCLE_FILL_EN
            sx    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (clear) begin
                        x_cnt <= '0;
                        y_cnt <= '0;
                    end else if (start) begin
                        cx_q  <= cx;
                        cy_q  <= cy;
                        r_q   <= radius;
                        col_q <= colour;
                    end
                end
                CLEAR: begin
                    if (pix.plot_rdy) begin
                        if (x_cnt == X_LAST) begin
                            x_cnt <= '0;
                            y_cnt <= y_cnt + Y_W'(1);
                        end else begin
                            x_cnt <= x_cnt + X_W'(1);
                        end
                    end
                end
                INIT: begin
                    px <= '0;
                    py <= {{(Q_W-R_W){1'b0}}, r_q};
                    d  <= D_W'(3) - (r_d <<< 1);
                    k  <= '0;
`ifdef CIRCLE_FILL_EN
                    sx <= '0;
`endif
                end
                PLOT: begin
                    if (adv) begin
`ifdef CIRCLE_FILL_EN
                        if (span_end) begin
                            sx <= '0;
                            k  <= k + 3'd1;
                        end else begin
                            sx <= sx + S_W'(1);
                        end
`else
                        k <= k + 3'd1;
`endif
                    end
                end
                STEP: begin
                    d  <= d_nx;
                    px <= px_nx;
                    py <= py_nx;
                    k  <= '0;
`ifdef CIRCLE_FILL_EN
                    sx <= '0;
`endif
                end
                default: ;
            endcase
        end
    end
endmodule
